// File: rtl/spram_port_ctrl.sv
// -----------------------------------------------------------------------------
// spram_port_ctrl
//
// Request/response controller between the core and a single-port SPRAM
// (SB_SPRAM256KA). Turns valid/ready requests into registered SPRAM address,
// data and write-enable strobes, and returns read data with a one-cycle
// rsp_valid pulse. After reset it can zero-fill the whole SPRAM before it
// accepts any request.
//
// Parameters
//   ADDR_BITS       SPRAM word-address width
//   DATA_BITS       SPRAM word width
//   CLEAR_ON_RESET  1: fill every address with CLEAR_VALUE after reset
//   CLEAR_VALUE     word written during the fill
//
// Ports
//   clk        system clock
//   reset      synchronous reset, active-high
//   req_valid  request present
//   req_ready  request accepted on an edge where req_valid & req_ready
//   req_wen    1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse, rsp_rdata holds a fresh read result
//   rsp_rdata  read data, held until the next read response
//   init_done  fill finished (or skipped); stays 1 until reset
//   ram_addr   to SPRAM ADDRESS (registered)
//   ram_wdata  to SPRAM DATAIN (registered)
//   ram_wen    to SPRAM WREN (registered)
//   ram_rdata  from SPRAM DATAOUT, valid the cycle after the SPRAM samples a read
//
// Read timing: accept edge E0 registers the address, the SPRAM samples it on
// E1 (RD1), the controller captures DATAOUT on E2 (RD2), and rsp_valid is high
// in the cycle after E2. That cycle is IDLE again, so a new request can be
// accepted while the response is presented.
// -----------------------------------------------------------------------------
module spram_port_ctrl #(
    parameter int unsigned          ADDR_BITS      = 14,
    parameter int unsigned          DATA_BITS      = 16,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_BITS-1:0] CLEAR_VALUE    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 init_done,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    output logic                 ram_wen,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD1   = 2'd2,
        ST_RD2   = 2'd3
    } state_t;

    localparam state_t               RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR   = '1;

    state_t               state_q;
    state_t               state_d;
    logic [ADDR_BITS-1:0] fill_cnt_q;
    logic                 accept;
    logic                 fill_last;

    // Ready only in IDLE once the fill has completed. init_done is still low in
    // the first IDLE cycle after the fill, which holds off requests until
    // init_done and req_ready rise together. Gating with reset keeps req_ready
    // low for the whole time reset is asserted, including the cycle before the
    // reset edge lands.
    assign req_ready = (state_q == ST_IDLE) && init_done && !reset;
    assign accept    = req_valid && req_ready;
    assign fill_last = (fill_cnt_q == LAST_ADDR);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps this purely
        // combinational; a path that leaves state_d unassigned would infer a latch.
        state_d = ST_IDLE;
        case (state_q)
            ST_CLEAR: state_d = fill_last ? ST_IDLE : ST_CLEAR;
            ST_IDLE:  state_d = (accept && !req_wen) ? ST_RD1 : ST_IDLE;
            ST_RD1:   state_d = ST_RD2;
            ST_RD2:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: SPRAM strobes, fill counter, response, init flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt_q <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wen    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            init_done  <= 1'b0;
        end else begin
            // Strobes default low; address and data hold unless overwritten.
            ram_wen   <= 1'b0;
            rsp_valid <= 1'b0;

            // Any edge outside CLEAR means the fill is over (or was skipped).
            if (state_q != ST_CLEAR) begin
                init_done <= 1'b1;
            end

            case (state_q)
                ST_CLEAR: begin
                    ram_addr   <= fill_cnt_q;
                    ram_wdata  <= CLEAR_VALUE;
                    ram_wen    <= 1'b1;
                    // Wraps back to 0 after the last address, ready for the
                    // next fill without an extra clear.
                    fill_cnt_q <= fill_cnt_q + ADDR_BITS'(1);
                end
                ST_IDLE: begin
                    if (accept) begin
                        ram_addr  <= req_addr;
                        ram_wdata <= req_wdata;
                        ram_wen   <= req_wen;
                    end
                end
                ST_RD2: begin
                    rsp_rdata <= ram_rdata;
                    rsp_valid <= 1'b1;
                end
                default: begin
                    // RD1: the SPRAM samples ram_addr on this edge; nothing to do.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spram_port_ctrl
//
// Directed bench for spram_port_ctrl with a behavioural SPRAM and a
// transaction-level reference model. The model counts edges since reset
// release, knows the fill occupies edges 1..16384, keeps a reference memory,
// and schedules each accepted read's response two edges after the accept.
// It compares every DUT output on every falling edge. Directed sequences add
// literal expectations (latencies, data words, edge counts).
// -----------------------------------------------------------------------------
module tb_spram_port_ctrl;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;

    int n_vec = 0;
    int n_err = 0;

    int            cyc = 0;
    int            rsp_times[$];
    logic [DW-1:0] rsp_datas[$];

    spram_port_ctrl #(
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE   (16'h0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wen  (ram_wen),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural SPRAM: registered read output, preloaded with 0xFFFF
    // -------------------------------------------------------------------------
    logic [DW-1:0] spram [0:WORDS-1];

    initial begin : spram_model
        for (int i = 0; i < WORDS; i++) spram[i] = 16'hFFFF;
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_wen) spram[ram_addr] = ram_wdata;
            else         ram_rdata <= spram[ram_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Reference model and per-cycle compare (runs on the falling edge)
    // -------------------------------------------------------------------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [0:WORDS-1];

    initial begin : ref_model
        rd_t           pend[$];
        int            n;
        bit            rst_last;
        bit            acc;
        logic          acc_wen;
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_data;
        logic          exp_wen;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic          exp_rsp;
        logic [DW-1:0] exp_rdata;
        logic          exp_done;
        logic          exp_ready;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = 16'hFFFF;
        n = 0; rst_last = 1'b1; acc = 1'b0;
        acc_wen = 1'b0; acc_addr = '0; acc_data = '0;
        exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rsp = 1'b0; exp_rdata = '0;

        forever begin
            @(negedge clk);
            cyc++;
            if (rst_last) begin
                // The edge just passed saw reset high.
                n = 0;
                pend.delete();
                acc       = 1'b0;
                exp_wen   = 1'b0;
                exp_addr  = '0;
                exp_wdata = '0;
                exp_rsp   = 1'b0;
                exp_rdata = '0;
            end else begin
                n++;
                exp_rsp = 1'b0;
                if (n <= WORDS) begin
                    exp_wen   = 1'b1;
                    exp_addr  = AW'(n - 1);
                    exp_wdata = 16'h0000;
                    ref_mem[n-1] = 16'h0000;
                end else if (acc) begin
                    exp_wen   = acc_wen;
                    exp_addr  = acc_addr;
                    exp_wdata = acc_data;
                end else begin
                    exp_wen = 1'b0;
                end
                acc = 1'b0;
                if (pend.size() > 0 && pend[0].due == n) begin
                    exp_rsp   = 1'b1;
                    exp_rdata = pend[0].data;
                    void'(pend.pop_front());
                end
            end
            exp_done  = !rst_last && (n >= WORDS + 1);
            exp_ready = exp_done && (pend.size() == 0) && !reset;

            check("ram_wen",   {31'd0, ram_wen},   {31'd0, exp_wen});
            check("ram_addr",  {18'd0, ram_addr},  {18'd0, exp_addr});
            check("ram_wdata", {16'd0, ram_wdata}, {16'd0, exp_wdata});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
            check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
            check("init_done", {31'd0, init_done}, {31'd0, exp_done});
            check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});

            if (rsp_valid === 1'b1) begin
                rsp_times.push_back(cyc);
                rsp_datas.push_back(rsp_rdata);
            end

            // Inputs are stable here and will be seen by the coming edge.
            if (req_valid && exp_ready) begin
                acc      = 1'b1;
                acc_wen  = req_wen;
                acc_addr = req_addr;
                acc_data = req_wdata;
                if (req_wen) ref_mem[req_addr] = req_wdata;
                else         pend.push_back('{n + 3, ref_mem[req_addr]});
            end
            rst_last = reset;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers. All input changes happen 1 time unit after a rising
    // edge; every helper returns at that same phase.
    // -------------------------------------------------------------------------
    task automatic issue(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int guard = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = data;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        int k = 0;
        bit got = 1'b0;
        issue(1'b0, addr, '0);
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (rsp_valid) got = 1'b1;
        end
        check({name, "_latency"}, k, 3);
        check({name, "_data"}, {16'd0, rsp_rdata}, {16'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int edges = 0;
        int wens  = 0;
        bit seen  = 1'b0;
        while (!seen && edges < 20000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ram_wen) wens++;
            if (init_done) seen = 1'b1;
        end
        check({name, "_edges"}, edges, WORDS + 1);
        check({name, "_wen_cycles"}, wens, WORDS);
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin : main
        int n_before;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: full fill over a RAM preloaded with 0xFFFF, then read a filled word.
        wait_init("fill1");
        read_expect("t1_rd1234", 14'h1234, 16'h0000);

        // 2: single write then readback.
        issue(1'b1, 14'h0010, 16'h2A5A);
        read_expect("t2_rd0010", 14'h0010, 16'h2A5A);

        // 3: four back-to-back writes, then readback of each word.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), DW'((i + 1) * 16'h0011));
        for (int i = 0; i < 4; i++) read_expect("t3_rd", AW'(i), DW'((i + 1) * 16'h0011));

        // 4: two reads with req_valid held; the second is accepted in the
        // first response cycle, so responses are 3 cycles apart.
        rsp_times.delete();
        rsp_datas.delete();
        issue(1'b0, 14'h0001, '0);
        issue(1'b0, 14'h0002, '0);
        repeat (4) @(negedge clk);
        check("t4_rsp_count", rsp_times.size(), 2);
        if (rsp_times.size() == 2) begin
            check("t4_rsp_spacing", rsp_times[1] - rsp_times[0], 3);
            check("t4_rsp0_data", {16'd0, rsp_datas[0]}, 32'h0022);
            check("t4_rsp1_data", {16'd0, rsp_datas[1]}, 32'h0033);
        end
        @(posedge clk);
        #1;

        // 5a: reset lands on the RD2 edge; the read must never respond.
        issue(1'b0, 14'h0003, '0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        n_before = rsp_times.size();
        repeat (4) @(negedge clk);
        check("t5_no_rsp_after_reset", rsp_times.size(), n_before);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 5b: interrupt the fill after it issued address 100, then refill.
        repeat (101) @(posedge clk);
        #1;
        check("t5_fill_addr_at_interrupt", {18'd0, ram_addr}, 32'd100);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_init("fill2");
        read_expect("t5_rd0003_cleared", 14'h0003, 16'h0000);

        // 6: top and bottom addresses are independent words.
        issue(1'b1, 14'h3FFF, 16'hBEEF);
        issue(1'b1, 14'h0000, 16'h1234);
        read_expect("t6_rd3FFF", 14'h3FFF, 16'hBEEF);
        read_expect("t6_rd0000", 14'h0000, 16'h1234);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
